// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and digit helpers for the radix-4 Booth multiplier
//
// Purpose : FSM state enum, Booth digit enum, triplet decode and digit value helpers.
// Ports   : none (package).

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Triplet {b[2i+1], b[2i], b[2i-1]} -> radix-4 digit
  function automatic booth_digit_e booth_decode(input logic [2:0] trip);
    booth_digit_e d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  // Digit as a 3-bit two's complement value in -2..+2
  function automatic logic [2:0] booth_digit_val(input booth_digit_e d);
    logic [2:0] v;
    case (d)
      POS1:    v = 3'b001;
      POS2:    v = 3'b010;
      NEG1:    v = 3'b111;
      NEG2:    v = 3'b110;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/booth_r4_digit_sel.sv
// rtl/booth_r4_digit_sel.sv - radix-4 Booth triplet decode and multiplicand select/negate
//
// Purpose : combinational; turns one multiplier triplet into the unshifted partial
//           product {0, +M, +2M, -M, -2M} for the extended multiplicand M.
// Ports   : i_triplet [2:0]      multiplier bits {b[2i+1], b[2i], b[2i-1]}
//           i_mcand   [WIDTH+1:0] extended multiplicand (two's complement)
//           o_pp      [WIDTH+2:0] selected multiple, two's complement

module booth_r4_digit_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_triplet,
  input  logic [WIDTH+1:0] i_mcand,
  output logic [WIDTH+2:0] o_pp
);

  booth_digit_e     w_digit;
  logic [WIDTH+2:0] w_m1;
  logic [WIDTH+2:0] w_m2;

  assign w_digit = booth_decode(i_triplet);

  // One extra bit so that 2M and -2M of any extended operand stay representable
  assign w_m1 = {i_mcand[WIDTH+1], i_mcand};
  assign w_m2 = {i_mcand, 1'b0};

  always_comb begin
    o_pp = '0;
    case (w_digit)
      POS1:    o_pp = w_m1;
      POS2:    o_pp = w_m2;
      NEG1:    o_pp = -w_m1;
      NEG2:    o_pp = -w_m2;
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - sequential radix-4 Booth multiplier, one digit per cycle
//
// Purpose : signed/unsigned WIDTH x WIDTH -> 2*WIDTH multiply with valid/ready handshakes.
//           Optional debug ports enabled by macro BOOTH_R4_DEBUG_EN.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready, a, b, is_signed  - operand handshake
//           out_valid/out_ready, p               - product handshake
//           dbg_pp, dbg_digit                    - BOOTH_R4_DEBUG_EN only

module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
`ifdef BOOTH_R4_DEBUG_EN
  ,
  output logic [2*WIDTH-1:0]   dbg_pp,
  output logic [2:0]           dbg_digit
`endif
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int PW   = 2 * WIDTH;
  localparam int EW   = WIDTH + 2;
  localparam int CW   = $clog2(NDIG);
  localparam int IW   = $clog2(WIDTH + 3);

  state_e          r_state;
  state_e          w_next;
  logic [EW-1:0]   r_a;
  logic [EW-1:0]   r_b;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_p;
  logic [CW-1:0]   r_cnt;

  logic            w_last;
  logic [EW:0]     w_b3;
  logic [IW-1:0]   w_idx;
  logic [2:0]      w_trip;
  logic [EW:0]     w_pp;
  logic [PW-1:0]   w_pp_ext;
  logic [PW-1:0]   w_pp_sh;
  logic [PW-1:0]   w_sum;

  assign w_last = (r_cnt == CW'(NDIG - 1));

  // Appending b[-1]=0 makes digit i the 3-bit slice starting at bit 2i
  assign w_b3   = {r_b, 1'b0};
  assign w_idx  = IW'({r_cnt, 1'b0});
  assign w_trip = w_b3[w_idx +: 3];

  booth_r4_digit_sel #(
    .WIDTH (WIDTH)
  ) u_digit_sel (
    .i_triplet (w_trip),
    .i_mcand   (r_a),
    .o_pp      (w_pp)
  );

  assign w_pp_ext = {{(PW - EW - 1){w_pp[EW]}}, w_pp};
  assign w_pp_sh  = w_pp_ext << w_idx;
  assign w_sum    = r_acc + w_pp_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            r_b   <= is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        BUSY: begin
          r_acc <= w_sum;
          if (w_last) begin
            r_p <= w_sum;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign p = r_p;

`ifdef BOOTH_R4_DEBUG_EN
  assign dbg_pp    = (r_state == BUSY) ? w_pp_sh : '0;
  assign dbg_digit = (r_state == BUSY) ? booth_digit_val(booth_decode(w_trip)) : 3'd0;
`endif

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - self-checking bench for booth_r4_seq_mult (WIDTH=32)

module tb_booth_r4_seq_mult;

  localparam int W    = 32;
  localparam int NDIG = W / 2 + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] p;

  int checks;
  int failures;

  booth_r4_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx;
    longint sy;
    logic [63:0] ux;
    logic [63:0] uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after the accept edge
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    a         = ta;
    b         = tb;
    is_signed = ts;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(NDIG));
    chk({tag, "_p"}, p, exp);
  endtask

  task automatic handshake(input string tag, input logic [63:0] exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ov_after"}, 64'(out_valid), 64'd0);
    chk({tag, "_ir_after"}, 64'(in_ready), 64'd1);
    chk({tag, "_p_held"}, p, exp);
  endtask

  task automatic full_op(input string tag, input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    logic [63:0] e;
    e = ref_mul(ta, tb, ts);
    start_op(ta, tb, ts);
    wait_done(tag, e);
    handshake(tag, e);
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_p", p, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    full_op("s_15x3", 32'd15, 32'd3, 1'b1);
    full_op("s_m25x12", -32'sd25, 32'd12, 1'b1);
    full_op("s_12345xm6789", 32'd12345, -32'sd6789, 1'b1);
    full_op("s_m1024xm2048", -32'sd1024, -32'sd2048, 1'b1);
    full_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    full_op("s_minneg", 32'h8000_0000, 32'h8000_0000, 1'b1);
    full_op("u_minneg", 32'h8000_0000, 32'h8000_0000, 1'b0);
    full_op("s_m1xmin", 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    full_op("u_zero", 32'd0, 32'hDEAD_BEEF, 1'b0);

    // Backpressure: product must stay put and a fresh in_valid must be ignored
    e = ref_mul(32'd99991, 32'hABCD_1234, 1'b1);
    start_op(32'd99991, 32'hABCD_1234, 1'b1);
    wait_done("bp", e);
    a        = 32'd123;
    b        = 32'd456;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ov_hold", 64'(out_valid), 64'd1);
      chk("bp_ir_low", 64'(in_ready), 64'd0);
      chk("bp_p_hold", p, e);
    end
    in_valid = 1'b0;
    handshake("bp", e);
    full_op("after_bp", 32'd77, 32'hFFFF_FF00, 1'b0);

    // Reset while digit 8 is being retired
    start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_p", p, 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_idle", 64'(in_ready), 64'd1);
    full_op("s_7xm7", 32'd7, -32'sd7, 1'b1);

    // Randomized operands against the arithmetic reference
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h7FFF_FFFF;
        default: ;
      endcase
      full_op("rand", ra, rb, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_mult.md
BOOTH_R4_SEQ_MULT -- requirements
Module: booth_r4_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are even and at least 4.
REQ-002 SHALL have derived localparam NDIG = WIDTH/2+1, the number of radix-4 digits per operation.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, operands present.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts operands.
REQ-007 SHALL have port a, input, WIDTH bits, multiplicand.
REQ-008 SHALL have port b, input, WIDTH bits, multiplier.
REQ-009 SHALL have port is_signed, input, 1 bit: 1 treats a and b as two's complement; 0 treats them as unsigned.
REQ-010 SHALL have port out_valid, output, 1 bit, product present.
REQ-011 SHALL have port out_ready, input, 1 bit, consumer accepts the product.
REQ-012 SHALL have port p, output, 2*WIDTH bits, product.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 SHALL capture a, b and is_signed on an edge with in_valid&&in_ready, then go IDLE->BUSY and clear the accumulator and digit counter.
REQ-015 SHALL extend the operands to WIDTH+2 bits at capture: sign-extend when is_signed=1, zero-extend when 0.
REQ-016 SHALL, in BUSY, retire exactly one Booth radix-4 digit per cycle, LSB digit first.
  - Digit encoding: triplet b[2i+1:2i-1] with b[-1]=0.
  - Digit value: one of {0,+1,+2,-1,-2} times the extended multiplicand.
  - The partial product is shifted left 2i and added modulo 2^(2*WIDTH).
REQ-017 SHALL go BUSY->DONE after digit NDIG-1 is retired; out_valid rises exactly NDIG cycles after the accept edge (17 for WIDTH=32).
REQ-018 SHALL hold p and out_valid stable in DONE until out_valid&&out_ready; on that edge it returns to IDLE.
REQ-019 SHALL leave p unchanged after the handshake until the next operation completes.
REQ-020 SHALL give p equal to the exact product modulo 2^(2*WIDTH) for all operand values, including the most-negative operand, in both modes.
REQ-021 SHALL ignore in_valid outside IDLE, and SHALL NOT alter captured operands during BUSY or DONE.
REQ-022 SHALL return to IDLE in the cycle after the handshake, so the earliest next accept is one cycle after the output handshake; there is no accept/deliver overlap.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-operation, asynchronously force:
  - state to IDLE;
  - in_ready=1, out_valid=0;
  - p, accumulator, captured operands and digit counter to 0.
REQ-024 SHALL discard any in-flight operation on reset; after rst_n rises, the first accept edge starts a fresh operation.

Configuration
REQ-025 SHALL, with macro BOOTH_R4_DEBUG_EN defined, add two output ports:
  - dbg_pp (2*WIDTH bits): the shifted partial product being added this cycle, 0 outside BUSY.
  - dbg_digit (3 bits): signed digit value -2..+2 in two's complement, 0 outside BUSY.
REQ-026 SHALL, without BOOTH_R4_DEBUG_EN, have neither debug port nor the logic driving them; functional behaviour is identical in both builds.

Structure
REQ-027 SHALL place the FSM state enum and the Booth digit encoding type (ZERO, POS1, POS2, NEG1, NEG2) in shared package booth_pkg.
REQ-028 SHALL place the triplet-to-digit decode and multiplicand select/negate in combinational sub-module booth_r4_digit_sel, instantiated once.

Verification
REQ-029 SHALL cover signed small operands: is_signed=1, a=15, b=3 -> p=45, out_valid exactly 17 cycles after accept.
REQ-030 SHALL cover signed mixed signs: is_signed=1, a=-25, b=12 -> p=-300 (0xFFFFFFFFFFFFFED4); a=12345, b=-6789 -> p=-83810205.
REQ-031 SHALL cover signed negatives and unsigned extremes:
  - is_signed=1, a=-1024, b=-2048 -> p=2097152.
  - is_signed=0, a=b=0xFFFFFFFF -> p=0xFFFFFFFE00000001.
  - is_signed=1, a=b=0x80000000 -> p=0x4000000000000000.
REQ-032 SHALL cover backpressure: hold out_ready=0 for 5 cycles in DONE -> p and out_valid stable, in_ready=0, and a new in_valid is ignored.
REQ-033 SHALL cover reset mid-operation: assert rst_n low during BUSY digit 8 -> immediate IDLE, outputs 0; the next operation 7*-7 signed -> -49.
